// File: rtl/a_arbiter_ctrl.sv
// Central serial-bus arbiter: fixed-priority / round-robin grant, cmd handshake, ACK watchdog.
// Define ARB_PREEMPT_EN to add one-level preemption with saved-context resume.
module a_arbiter_ctrl #(
  parameter int NO_MASTERS  = 4,
  parameter int NO_SLAVES   = 3,
  parameter int THRESH      = 1000,
  parameter int ACK_TIMEOUT = 64,
  parameter int S_ID_WIDTH  = $clog2(NO_SLAVES + 1),
  parameter int M_ID_WIDTH  = $clog2(NO_MASTERS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NO_MASTERS*S_ID_WIDTH-1:0] req_id,
  input  logic [NO_MASTERS*2-1:0]          com_state,
  input  logic [NO_MASTERS-1:0]            done,
  input  logic                             rr_mode,
  output logic [NO_MASTERS*2-1:0]          cmd,
  output logic [M_ID_WIDTH+S_ID_WIDTH-1:0] bus_state,
  output logic                             bus_valid,
  output logic                             timeout_err
);

  localparam int WD_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] CMD_WAIT  = 2'b00;
  localparam logic [1:0] CMD_CLEAR = 2'b11;
  localparam logic [1:0] COM_END   = 2'b00;
  localparam logic [1:0] COM_NAK   = 2'b01;
  localparam logic [1:0] COM_COM   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ALLOC, S_ACK, S_COM, S_PREEMPT, S_OVER
  } state_t;

  state_t                  state;
  logic [M_ID_WIDTH-1:0]   cur_master;
  logic [S_ID_WIDTH-1:0]   cur_slave;
  logic [M_ID_WIDTH-1:0]   last_grant;
  logic [WD_W-1:0]         wd_cnt;

  logic [S_ID_WIDTH-1:0]   req_arr [NO_MASTERS];
  logic [1:0]              com_arr [NO_MASTERS];
  logic                    req_any;
  logic [M_ID_WIDTH-1:0]   fix_win;
  logic [M_ID_WIDTH-1:0]   rr_win;
  logic [M_ID_WIDTH-1:0]   rr_idx;
  logic [M_ID_WIDTH-1:0]   win;

`ifdef ARB_PREEMPT_EN
  localparam int HOLD_W = $clog2(THRESH + 1);
  localparam logic [1:0] CMD_STOP_S = 2'b01;
  localparam logic [1:0] CMD_STOP_P = 2'b10;

  logic [HOLD_W-1:0]       hold_cnt;
  logic [M_ID_WIDTH-1:0]   old_master;
  logic [S_ID_WIDTH-1:0]   old_slave;
  logic [M_ID_WIDTH-1:0]   next_master;
  logic [S_ID_WIDTH-1:0]   next_slave;
  logic                    ctx_valid;
  logic                    intr_route;
  logic                    mode_rr;
`else
  wire unused_nopreempt = (^done) ^ (THRESH > 0);
`endif

  // Command word with a single master addressed; every other master sees WAIT.
  function automatic logic [NO_MASTERS*2-1:0] cmd_for(input logic [M_ID_WIDTH-1:0] idx,
                                                      input logic [1:0] code);
    logic [NO_MASTERS*2-1:0] v;
    v = {NO_MASTERS{CMD_WAIT}};
    v[int'(idx)*2 +: 2] = code;
    return v;
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    req_any = 1'b0;
    fix_win = '0;
    rr_win  = '0;
    rr_idx  = '0;
    for (int i = NO_MASTERS - 1; i >= 0; i--) begin
      req_arr[i] = req_id[i*S_ID_WIDTH +: S_ID_WIDTH];
      com_arr[i] = com_state[i*2 +: 2];
      if (req_arr[i] != '0) begin
        req_any = 1'b1;
        fix_win = M_ID_WIDTH'(i);
      end
    end
    // Walk backwards so the candidate closest after last_grant is written last.
    for (int k = NO_MASTERS; k >= 1; k--) begin
      rr_idx = M_ID_WIDTH'((int'(last_grant) + k) % NO_MASTERS);
      if (req_arr[rr_idx] != '0) rr_win = rr_idx;
    end
    win = rr_mode ? rr_win : fix_win;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd         <= {NO_MASTERS{CMD_WAIT}};
      bus_state   <= '0;
      bus_valid   <= 1'b0;
      timeout_err <= 1'b0;
      last_grant  <= M_ID_WIDTH'(NO_MASTERS - 1);
      cur_master  <= '0;
      cur_slave   <= '0;
      wd_cnt      <= '0;
`ifdef ARB_PREEMPT_EN
      hold_cnt    <= '0;
      old_master  <= '0;
      old_slave   <= '0;
      next_master <= '0;
      next_slave  <= '0;
      ctx_valid   <= 1'b0;
      intr_route  <= 1'b0;
      mode_rr     <= 1'b0;
`endif
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_any) begin
            cur_master <= win;
            cur_slave  <= req_arr[win];
            last_grant <= win;
`ifdef ARB_PREEMPT_EN
            mode_rr    <= rr_mode;
`endif
            state      <= S_ALLOC;
          end
        end

        S_ALLOC: begin
          cmd    <= cmd_for(cur_master, CMD_CLEAR);
          wd_cnt <= '0;
`ifdef ARB_PREEMPT_EN
          hold_cnt <= '0;
`endif
          state  <= S_ACK;
        end

        S_ACK: begin
          if (com_arr[cur_master] == COM_COM) begin
            bus_state <= {cur_master, cur_slave};
            bus_valid <= 1'b1;
            state     <= S_COM;
          end else if (com_arr[cur_master] == COM_NAK) begin
            state <= S_OVER;
          end else if (wd_cnt == WD_W'(ACK_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_OVER;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end

        S_COM: begin
          if (com_arr[cur_master] == COM_END) begin
            bus_state <= '0;
            bus_valid <= 1'b0;
            state     <= S_OVER;
          end
`ifdef ARB_PREEMPT_EN
          else if (!mode_rr && !ctx_valid && !intr_route && req_any && (fix_win < cur_master)) begin
            old_master  <= cur_master;
            old_slave   <= cur_slave;
            next_master <= fix_win;
            next_slave  <= req_arr[fix_win];
            ctx_valid   <= 1'b1;
            bus_state   <= '0;
            bus_valid   <= 1'b0;
            cmd         <= cmd_for(cur_master,
                                   (hold_cnt >= HOLD_W'(THRESH)) ? CMD_STOP_S : CMD_STOP_P);
            state       <= S_PREEMPT;
          end
          if (hold_cnt != HOLD_W'(THRESH)) hold_cnt <= hold_cnt + HOLD_W'(1);
`endif
        end

`ifdef ARB_PREEMPT_EN
        S_PREEMPT: begin
          if (done[cur_master]) begin
            cur_master <= next_master;
            cur_slave  <= next_slave;
            intr_route <= 1'b1;
            state      <= S_ALLOC;
          end
        end
`endif

        S_OVER: begin
          cmd <= {NO_MASTERS{CMD_WAIT}};
`ifdef ARB_PREEMPT_EN
          if (ctx_valid) begin
            cur_master <= old_master;
            cur_slave  <= old_slave;
            ctx_valid  <= 1'b0;
            intr_route <= 1'b0;
            state      <= S_ALLOC;
          end else begin
            state <= S_IDLE;
          end
`else
          state <= S_IDLE;
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a_arbiter_ctrl.sv
// Self-checking bench for a_arbiter_ctrl: scripted masters plus a route scoreboard.
module tb_a_arbiter_ctrl;

  localparam logic [1:0] CMD_WAIT = 2'b00, CMD_STOP_S = 2'b01, CMD_STOP_P = 2'b10, CMD_CLEAR = 2'b11;
  localparam logic [1:0] COM_END = 2'b00, COM_WAIT = 2'b10, COM_COM = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rr_mode = 1'b0;
  logic [1:0] req_arr [4];
  logic [1:0] com_arr [4];
  logic [3:0] done_v = '0;
  logic [7:0] req_flat;
  logic [7:0] com_flat;
  logic [7:0] cmd;
  logic [3:0] bus_state;
  logic       bus_valid;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [$];
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    req_flat = '0;
    com_flat = '0;
    for (int i = 0; i < 4; i++) begin
      req_flat[i*2 +: 2] = req_arr[i];
      com_flat[i*2 +: 2] = com_arr[i];
    end
  end

  a_arbiter_ctrl #(.NO_MASTERS(4), .NO_SLAVES(3), .THRESH(10), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_id(req_flat), .com_state(com_flat), .done(done_v),
    .rr_mode(rr_mode), .cmd(cmd), .bus_state(bus_state), .bus_valid(bus_valid),
    .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] cmd_of(input int m);
    return cmd[m*2 +: 2];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each new route is compared against the oldest expected route.
  always @(negedge clk) begin
    if (bus_valid && !prev_valid) begin
      check("sb_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("sb_route", bus_state, exp_q.pop_front());
    end
    prev_valid = bus_valid;
  end

  task automatic wait_clear(input int budget, output int who);
    who = -1;
    for (int n = 0; n < budget && who < 0; n++) begin
      tick();
      for (int m = 0; m < 4; m++) if (cmd_of(m) == CMD_CLEAR) who = m;
    end
  endtask

  task automatic serve(input int m, input int n_com, input bit drop_req, input string tag);
    int who;
    exp_q.push_back({2'(m), req_arr[m]});
    wait_clear(40, who);
    check({tag, "_grant"}, who, m);
    com_arr[m] = COM_COM;
    tick();
    check({tag, "_valid"}, bus_valid, 1);
    repeat (n_com - 1) tick();
    com_arr[m] = COM_END;
    if (drop_req) req_arr[m] = 2'd0;
    tick();
    check({tag, "_drop"}, bus_valid, 0);
  endtask

  // Master 2 (slave 1) in COM, master 0 (slave 2) requests after pre_cycles more cycles.
  task automatic preempt_case(input int pre_cycles, input logic [1:0] exp_stop, input string tag);
    int who;
    req_arr[2] = 2'd1;
    exp_q.push_back(4'b1001);
    wait_clear(10, who);
    check({tag, "_g2"}, who, 2);
    com_arr[2] = COM_COM;
    tick();
    repeat (pre_cycles) tick();
    req_arr[0] = 2'd2;
    tick();
`ifdef ARB_PREEMPT_EN
    check({tag, "_stop"}, cmd_of(2), exp_stop);
    check({tag, "_route_cut"}, {bus_valid, bus_state}, 5'd0);
    check({tag, "_m0_wait"}, cmd_of(0), CMD_WAIT);
    done_v[2] = 1'b1;
    com_arr[2] = COM_END;
    exp_q.push_back(4'b0010);
    tick();
    done_v[2] = 1'b0;
    check({tag, "_done_lat1"}, cmd_of(0), CMD_WAIT);
    tick();
    check({tag, "_done_clear"}, cmd_of(0), CMD_CLEAR);
    check({tag, "_m2_wait"}, cmd_of(2), CMD_WAIT);
    com_arr[0] = COM_COM;
    tick();
    check({tag, "_m0_valid"}, bus_valid, 1);
    repeat (2) tick();
    com_arr[0] = COM_END;
    req_arr[0] = 2'd0;
    tick();
    check({tag, "_m0_drop"}, bus_valid, 0);
    exp_q.push_back(4'b1001);
    wait_clear(10, who);
    check({tag, "_resume"}, who, 2);
    com_arr[2] = COM_COM;
    tick();
    check({tag, "_resume_valid"}, bus_valid, 1);
    com_arr[2] = COM_END;
    req_arr[2] = 2'd0;
    tick();
    check({tag, "_resume_drop"}, bus_valid, 0);
`else
    check({tag, "_no_stop"}, cmd_of(2), CMD_CLEAR);
    check({tag, "_kept"}, bus_valid, (exp_stop == CMD_STOP_S) ? 1'b1 : 1'b1);
    com_arr[2] = COM_END;
    req_arr[2] = 2'd0;
    tick();
    check({tag, "_m2_drop"}, bus_valid, 0);
    serve(0, 3, 1'b1, {tag, "_m0"});
`endif
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int who;
    for (int i = 0; i < 4; i++) begin
      req_arr[i] = 2'd0;
      com_arr[i] = COM_END;
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_cmd", cmd, 8'h00);
    check("rst_bus_state", bus_state, 4'h0);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_timeout", timeout_err, 0);

    // Fixed mode, single request: CLEAR two edges after the request.
    req_arr[2] = 2'd1;
    tick();
    check("fix_lat1", cmd_of(2), CMD_WAIT);
    tick();
    check("fix_clear", cmd_of(2), CMD_CLEAR);
    exp_q.push_back(4'b1001);
    com_arr[2] = COM_COM;
    tick();
    check("fix_valid", bus_valid, 1);
    check("fix_route", bus_state, 4'b1001);
    repeat (3) tick();
    com_arr[2] = COM_END;
    req_arr[2] = 2'd0;
    tick();
    check("fix_drop", {bus_valid, bus_state}, 5'd0);
    tick();
    check("fix_over_wait", cmd, 8'h00);
    repeat (2) tick();

    // ACK watchdog: master 1 never leaves wait_ack.
    req_arr[1] = 2'd2;
    com_arr[1] = COM_WAIT;
    wait_clear(10, who);
    check("wd_grant", who, 1);
    repeat (7) tick();
    check("wd_early", timeout_err, 0);
    tick();
    check("wd_pulse", timeout_err, 1);
    req_arr[1] = 2'd0;
    com_arr[1] = COM_END;
    tick();
    check("wd_pulse_end", timeout_err, 0);
    check("wd_cmd_wait", cmd_of(1), CMD_WAIT);
    check("wd_no_route", bus_valid, 0);
    repeat (2) tick();

    // Reset in the middle of a transfer.
    req_arr[1] = 2'd3;
    exp_q.push_back(4'b0111);
    wait_clear(10, who);
    check("rstc_grant", who, 1);
    com_arr[1] = COM_COM;
    tick();
    check("rstc_valid", bus_valid, 1);
    tick();
    rst = 1'b1;
    tick();
    check("rstc_route", {bus_valid, bus_state}, 5'd0);
    check("rstc_cmd", cmd, 8'h00);
    rst = 1'b0;
    req_arr[1] = 2'd0;
    com_arr[1] = COM_END;
    repeat (2) tick();

    // Round robin from reset: grants 0,1,3,0.
    rr_mode = 1'b1;
    req_arr[0] = 2'd1;
    req_arr[1] = 2'd2;
    req_arr[3] = 2'd3;
    serve(0, 5, 1'b0, "rr_a");
    serve(1, 5, 1'b0, "rr_b");
    serve(3, 5, 1'b0, "rr_c");
    serve(0, 5, 1'b1, "rr_d");
    req_arr[1] = 2'd0;
    req_arr[3] = 2'd0;
    repeat (3) tick();
    rr_mode = 1'b0;

    preempt_case(19, CMD_STOP_S, "pre_soft");
    preempt_case(2, CMD_STOP_P, "pre_hard");

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
